// File: rtl/frame_scaler_pkg.sv
// Shared definitions for the frame_scaler pyramid downscaler.
//   DEFAULT_* : default widths and fixed-point format
//   ONE_STEP  : a scale step of exactly 1.0 in the default format
//   state_t   : scaler control state (IDLE / ACTIVE)
//   beat_t    : one output beat at the default widths {pixel, x, y, sof, eol}
//   beat_width: packed width of a beat for arbitrary pixel/coord widths
package frame_scaler_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 8;
    localparam int DEFAULT_COORD_WIDTH = 16;
    localparam int DEFAULT_FRAC_BITS   = 8;
    localparam int ONE_STEP            = 1 << DEFAULT_FRAC_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEFAULT_PIXEL_WIDTH-1:0] pixel;
        logic [DEFAULT_COORD_WIDTH-1:0] x;
        logic [DEFAULT_COORD_WIDTH-1:0] y;
        logic                           sof;
        logic                           eol;
    } beat_t;

    function automatic int beat_width(input int pixel_width, input int coord_width);
        return pixel_width + 2 * coord_width + 2;
    endfunction

endpackage

// File: rtl/frame_scaler_skid_fifo.sv
// scaler_skid_fifo: 2-entry valid/ready buffer for packed output beats.
//   clk, reset_os           : clock, asynchronous active-low reset (flushes)
//   push_valid/ready/data   : upstream side; push_ready = (count < 2)
//   pop_valid/ready/data    : downstream side; pop_data is held while not taken
// push_ready depends only on the stored count, never on pop_ready.
module scaler_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_os,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] mem_reg [2];
    logic [1:0]       count_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic             push;
    logic             pop;

    assign push_ready = (count_reg != 2'd2);
    assign pop_valid  = (count_reg != 2'd0);
    assign pop_data   = mem_reg[rd_ptr_reg];
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;

    always_ff @(posedge clk or negedge reset_os) begin
        if (!reset_os) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/frame_scaler.sv
// frame_scaler: streaming nearest-neighbour downscaler with a runtime
// fixed-point step (source pixels per destination pixel, clamped to >= 1.0).
//   i_valid/o_ready/i_pixel/i_sof/i_step : raster-order source stream
//   o_valid/i_ready/o_pixel/o_xcoord/o_ycoord/o_sof/o_eol : scaled stream
//   o_frame_done : pulse the cycle after the last source pixel is consumed
//   o_err        : sticky, set when sof arrives in the middle of a frame
module frame_scaler
    import frame_scaler_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH,
    parameter int SRC_WIDTH   = 10,
    parameter int SRC_HEIGHT  = 10,
    parameter int FRAC_BITS   = DEFAULT_FRAC_BITS
) (
    input  logic                   clk,
    input  logic                   reset_os,
    input  logic [COORD_WIDTH-1:0] i_step,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    input  logic                   i_sof,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [PIXEL_WIDTH-1:0] o_pixel,
    output logic [COORD_WIDTH-1:0] o_xcoord,
    output logic [COORD_WIDTH-1:0] o_ycoord,
    output logic                   o_sof,
    output logic                   o_eol,
    output logic                   o_frame_done,
    output logic                   o_err
);

    localparam int ACC_WIDTH  = COORD_WIDTH + FRAC_BITS;
    localparam int BEAT_WIDTH = beat_width(PIXEL_WIDTH, COORD_WIDTH);
    localparam logic [COORD_WIDTH-1:0] LAST_X    = COORD_WIDTH'(SRC_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_Y    = COORD_WIDTH'(SRC_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0] STEP_ONE  = COORD_WIDTH'(1) << FRAC_BITS;

    state_t                 state_reg, state_next;
    logic [COORD_WIDTH-1:0] step_reg, step_next;
    logic [COORD_WIDTH-1:0] src_x_reg, src_x_next, src_y_reg, src_y_next;
    logic [COORD_WIDTH-1:0] dst_x_reg, dst_x_next, dst_y_reg, dst_y_next;
    logic [ACC_WIDTH-1:0]   nx_reg, nx_next, ny_reg, ny_next;
    logic                   err_reg, err_next;
    logic                   frame_done_reg, frame_done_next;

    // Effective (this-transfer) view: a sof transfer behaves as if every
    // counter were already zero and the new step already latched.
    logic                   in_xfer, restart, take, sel, row_sel, eol;
    logic                   at_row_end, at_frame_end;
    logic [COORD_WIDTH-1:0] step_eff, cur_x, cur_y, cur_dx, cur_dy;
    logic [ACC_WIDTH-1:0]   cur_nx, cur_ny, step_ext, nx_sum, ny_sum;

    logic                   push_valid, push_ready, pop_valid;
    logic [BEAT_WIDTH-1:0]  push_data, pop_data;

    // State register
    always_ff @(posedge clk or negedge reset_os) begin
        if (!reset_os) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (restart) state_next = at_frame_end ? IDLE : ACTIVE;
            ACTIVE:  if (take)    state_next = at_frame_end ? IDLE : ACTIVE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        in_xfer  = i_valid & o_ready;
        restart  = in_xfer & i_sof;
        take     = in_xfer & ((state_reg == ACTIVE) | i_sof);
        step_eff = restart ? ((i_step < STEP_ONE) ? STEP_ONE : i_step) : step_reg;
        cur_x    = restart ? '0 : src_x_reg;
        cur_y    = restart ? '0 : src_y_reg;
        cur_dx   = restart ? '0 : dst_x_reg;
        cur_dy   = restart ? '0 : dst_y_reg;
        cur_nx   = restart ? '0 : nx_reg;
        cur_ny   = restart ? '0 : ny_reg;
        step_ext = {{FRAC_BITS{1'b0}}, step_eff};
        nx_sum   = cur_nx + step_ext;
        ny_sum   = cur_ny + step_ext;

        row_sel      = (cur_y == cur_ny[ACC_WIDTH-1:FRAC_BITS]);
        sel          = row_sel && (cur_x == cur_nx[ACC_WIDTH-1:FRAC_BITS]);
        eol          = (nx_sum[ACC_WIDTH-1:FRAC_BITS] > LAST_X);
        at_row_end   = (cur_x == LAST_X);
        at_frame_end = at_row_end && (cur_y == LAST_Y);

        push_valid = take & sel;
        push_data  = {i_pixel, cur_dx, cur_dy, restart, eol};

        step_next  = step_reg;
        src_x_next = src_x_reg;
        src_y_next = src_y_reg;
        dst_x_next = dst_x_reg;
        dst_y_next = dst_y_reg;
        nx_next    = nx_reg;
        ny_next    = ny_reg;
        if (take) begin
            step_next  = step_eff;
            src_y_next = cur_y;
            dst_y_next = cur_dy;
            ny_next    = cur_ny;
            if (at_row_end) begin
                src_x_next = '0;
                dst_x_next = '0;
                nx_next    = '0;
                if (at_frame_end) begin
                    src_y_next = '0;
                    dst_y_next = '0;
                    ny_next    = '0;
                end else begin
                    src_y_next = cur_y + COORD_ONE;
                    if (row_sel) begin
                        ny_next    = ny_sum;
                        dst_y_next = cur_dy + COORD_ONE;
                    end
                end
            end else begin
                src_x_next = cur_x + COORD_ONE;
                dst_x_next = sel ? cur_dx + COORD_ONE : cur_dx;
                nx_next    = sel ? nx_sum : cur_nx;
            end
        end

        // A sof exactly at (0,0) is a legal frame start, not an error.
        err_next        = err_reg | (restart & (state_reg == ACTIVE) &
                                     !((src_x_reg == '0) && (src_y_reg == '0)));
        frame_done_next = take & at_frame_end;
    end

    always_ff @(posedge clk or negedge reset_os) begin
        if (!reset_os) begin
            step_reg       <= STEP_ONE;
            src_x_reg      <= '0;
            src_y_reg      <= '0;
            dst_x_reg      <= '0;
            dst_y_reg      <= '0;
            nx_reg         <= '0;
            ny_reg         <= '0;
            err_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            step_reg       <= step_next;
            src_x_reg      <= src_x_next;
            src_y_reg      <= src_y_next;
            dst_x_reg      <= dst_x_next;
            dst_y_reg      <= dst_y_next;
            nx_reg         <= nx_next;
            ny_reg         <= ny_next;
            err_reg        <= err_next;
            frame_done_reg <= frame_done_next;
        end
    end

    scaler_skid_fifo #(
        .WIDTH (BEAT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset_os   (reset_os),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (i_ready),
        .pop_data   (pop_data)
    );

    assign o_ready      = push_ready;
    assign o_valid      = pop_valid;
    assign o_pixel      = pop_data[BEAT_WIDTH-1 -: PIXEL_WIDTH];
    assign o_xcoord     = pop_data[2*COORD_WIDTH+1 -: COORD_WIDTH];
    assign o_ycoord     = pop_data[COORD_WIDTH+1 -: COORD_WIDTH];
    assign o_sof        = pop_valid & pop_data[1];
    assign o_eol        = pop_valid & pop_data[0];
    assign o_frame_done = frame_done_reg;
    assign o_err        = err_reg;

endmodule

// File: tb/tb_frame_scaler.sv
module tb_frame_scaler;
    import frame_scaler_pkg::*;

    localparam int W = 10;
    localparam int H = 10;

    logic        clk = 1'b0;
    logic        reset_os;
    logic [15:0] i_step;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_pixel;
    logic        i_sof;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_pixel;
    logic [15:0] o_xcoord;
    logic [15:0] o_ycoord;
    logic        o_sof;
    logic        o_eol;
    logic        o_frame_done;
    logic        o_err;

    always #5 clk = ~clk;

    frame_scaler #(
        .PIXEL_WIDTH (8),
        .COORD_WIDTH (16),
        .SRC_WIDTH   (W),
        .SRC_HEIGHT  (H),
        .FRAC_BITS   (8)
    ) dut (
        .clk          (clk),
        .reset_os     (reset_os),
        .i_step       (i_step),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_pixel      (i_pixel),
        .i_sof        (i_sof),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pixel      (o_pixel),
        .o_xcoord     (o_xcoord),
        .o_ycoord     (o_ycoord),
        .o_sof        (o_sof),
        .o_eol        (o_eol),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    int          checks = 0;
    int          passes = 0;
    beat_t       exp_q[$];
    int          beats_seen = 0;
    int          frame_done_cnt = 0;
    logic        ready_low_seen = 1'b0;
    logic        hold_prev = 1'b0;
    beat_t       prev_beat;
    beat_t       obs_beat;
    logic [7:0]  frame_pix [W*H];
    int          stall_left = 0;
    int          stall_at = -1;
    logic        rand_ready = 1'b0;
    logic        bubbles = 1'b0;

    assign obs_beat = {o_pixel, o_xcoord, o_ycoord, o_sof, o_eol};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) i_ready = 1'b1;
        end else if (rand_ready) begin
            i_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Reference: destination index k maps to source floor(k*step); a frame's
    // output is the cross product of the selected rows and columns.
    task automatic expect_frame(input int step_raw, input int cut, output int n);
        int    sel[$];
        int    s;
        beat_t b;
        s = (step_raw < ONE_STEP) ? ONE_STEP : step_raw;
        for (int k = 0; ((k * s) >> DEFAULT_FRAC_BITS) < W; k++)
            sel.push_back((k * s) >> DEFAULT_FRAC_BITS);
        n = 0;
        for (int dy = 0; dy < sel.size(); dy++) begin
            for (int dx = 0; dx < sel.size(); dx++) begin
                int idx;
                idx = sel[dy] * W + sel[dx];
                if (idx < cut) begin
                    b.pixel = frame_pix[idx];
                    b.x     = 16'(dx);
                    b.y     = 16'(dy);
                    b.sof   = (dx == 0) && (dy == 0);
                    b.eol   = (dx == sel.size() - 1);
                    exp_q.push_back(b);
                    n++;
                end
            end
        end
    endtask

    task automatic drive_pixel(input logic [7:0] pix, input logic sof);
        int   tries;
        logic done;
        tries = 0;
        done  = 1'b0;
        i_valid = 1'b1;
        i_pixel = pix;
        i_sof   = sof;
        while (!done) begin
            @(negedge clk);
            if (o_ready) done = 1'b1;
            tick();
            if (!done) begin
                tries++;
                if (tries > 500) begin
                    chk("ready_timeout", 64'(o_ready), 64'd1);
                    done = 1'b1;
                end
            end
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_pixel = 8'($urandom);
        if (sof) i_step = 16'($urandom);
        if (bubbles) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic drive_range(input int first, input int last, input logic sof_first,
                               input logic [15:0] step);
        i_step = step;
        for (int i = first; i <= last; i++) begin
            if (i == stall_at) begin
                stall_left = 6;
                i_ready    = 1'b0;
            end
            drive_pixel(frame_pix[i], sof_first && (i == first));
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic run_frame(input string tag, input logic [15:0] step, input int exp_n,
                             input logic chk_lat);
        int n, base, fd_base;
        expect_frame(int'(step), W * H, n);
        base    = beats_seen;
        fd_base = frame_done_cnt;
        drive_range(0, 0, 1'b1, step);
        if (chk_lat) begin
            chk({tag, "_latency_valid"}, 64'(o_valid), 64'd1);
            chk({tag, "_latency_sof"}, 64'(o_sof), 64'd1);
        end
        drive_range(1, W * H - 1, 1'b0, step);
        wait_drain(tag);
        chk({tag, "_count"}, 64'(beats_seen - base), 64'((exp_n < 0) ? n : exp_n));
        chk({tag, "_frame_done"}, 64'(frame_done_cnt - fd_base), 64'd1);
        $display("frame %s step=%h beats=%0d", tag, step, beats_seen - base);
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < W * H; i++) frame_pix[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < W * H; i++) frame_pix[i] = 8'($urandom);
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : mon
        beat_t e;
        if (reset_os) begin
            if (hold_prev)
                chk("hold_stable", 64'({o_valid, obs_beat}), 64'({1'b1, prev_beat}));
            if (!o_ready) begin
                ready_low_seen = 1'b1;
                chk("ready_low_means_full", 64'(o_valid), 64'd1);
            end
            if (o_frame_done) frame_done_cnt++;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(o_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", beats_seen), 64'(obs_beat), 64'(e));
                end
                beats_seen++;
            end
            hold_prev = o_valid && !i_ready;
            prev_beat = obs_beat;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, fd_base;
        reset_os = 1'b0;
        i_step   = 16'h0100;
        i_valid  = 1'b0;
        i_pixel  = 8'd0;
        i_sof    = 1'b0;
        i_ready  = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 64'({o_valid, o_sof, o_eol, o_frame_done, o_err,
                                  o_pixel, o_xcoord, o_ycoord}), 64'd0);
        reset_os = 1'b1;
        tick();
        chk("ready_after_release", 64'(o_ready), 64'd1);
        chk("err_after_release", 64'(o_err), 64'd0);

        // Half-size, pattern pixels, sink always ready
        fill_pattern();
        run_frame("half", 16'h0200, 25, 1'b1);

        // Unity and clamped-upscale steps with random handshakes
        rand_ready = 1'b1;
        bubbles    = 1'b1;
        fill_random();
        run_frame("unity", 16'h0100, 100, 1'b0);
        run_frame("clamp", 16'h0080, 100, 1'b0);

        fill_pattern();
        run_frame("step1p5", 16'h0180, 49, 1'b0);

        // Back-pressure: sink stalls 6 cycles mid-row
        rand_ready     = 1'b0;
        bubbles        = 1'b0;
        i_ready        = 1'b1;
        tick();
        ready_low_seen = 1'b0;
        stall_at       = 41;
        run_frame("stall", 16'h0200, 25, 1'b0);
        chk("stall_ready_fell", 64'(ready_low_seen), 64'd1);
        stall_at = -1;

        // Random steps and pixels
        rand_ready = 1'b1;
        bubbles    = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_frame($sformatf("rand%0d", r), 16'($urandom_range(32'h40, 32'h500)), -1, 1'b0);
        end
        fill_random();
        run_frame("huge_step", 16'h0C00, 1, 1'b0);

        // sof reasserted at source (5,3)
        chk("err_before_restart", 64'(o_err), 64'd0);
        base    = beats_seen;
        fd_base = frame_done_cnt;
        fill_random();
        expect_frame(32'h100, 35, n);
        drive_range(0, 34, 1'b1, 16'h0100);
        chk("err_still_clear", 64'(o_err), 64'd0);
        fill_random();
        expect_frame(32'h200, W * H, n);
        drive_range(0, 0, 1'b1, 16'h0200);
        chk("err_set", 64'(o_err), 64'd1);
        drive_range(1, W * H - 1, 1'b0, 16'h0200);
        wait_drain("restart");
        chk("restart_count", 64'(beats_seen - base), 64'd60);
        chk("restart_frame_done", 64'(frame_done_cnt - fd_base), 64'd1);
        chk("err_sticky", 64'(o_err), 64'd1);
        $display("frame restart beats=%0d err=%0b", beats_seen - base, o_err);

        // Reset at source (4,4)
        rand_ready = 1'b0;
        bubbles    = 1'b0;
        i_ready    = 1'b1;
        tick();
        fd_base = frame_done_cnt;
        fill_pattern();
        expect_frame(32'h200, 45, n);
        drive_range(0, 44, 1'b1, 16'h0200);
        reset_os = 1'b0;
        exp_q.delete();
        tick();
        tick();
        chk("mid_reset_outputs", 64'({o_valid, o_sof, o_eol, o_frame_done, o_err,
                                      o_pixel, o_xcoord, o_ycoord}), 64'd0);
        reset_os = 1'b1;
        tick();
        base = beats_seen;
        for (int i = 0; i < 7; i++) drive_pixel(8'($urandom), 1'b0);
        repeat (4) tick();
        chk("dropped_no_output", 64'(beats_seen - base), 64'd0);
        chk("reset_no_frame_done", 64'(frame_done_cnt - fd_base), 64'd0);
        fill_random();
        run_frame("after_reset", 16'h0200, 25, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/frame_scaler.md
Name: frame_scaler

Overview:
Streaming nearest-neighbour downscaler for the face-detection pyramid. It generalises the fixed half-size coordinate resize to a runtime fixed-point scale step and carries the pixel data, not just coordinates. It has valid/ready handshakes on both sides and a 2-entry output buffer. It sits between the pixel source and the line-buffer memory, so each pyramid level can be produced by one instance.

Parameters:
PIXEL_WIDTH, 8, pixel data width
COORD_WIDTH, 16, width of source/destination coordinate counters
SRC_WIDTH, 10, source frame width in pixels
SRC_HEIGHT, 10, source frame height in pixels
FRAC_BITS, 8, fractional bits of the scale step (step is Q(COORD_WIDTH-FRAC_BITS).FRAC_BITS)

Ports:
clk  in  1  clock; all logic on rising edge
reset_os  in  1  asynchronous, active-low reset
i_step  in  COORD_WIDTH  source pixels per destination pixel, fixed-point; latched at start of frame
i_valid  in  1  input pixel valid
o_ready  out  1  block can accept input this cycle
i_pixel  in  PIXEL_WIDTH  input pixel, raster order
i_sof  in  1  marks first pixel (0,0) of a frame; qualified by i_valid
o_valid  out  1  output pixel valid
i_ready  in  1  downstream accepts output
o_pixel  out  PIXEL_WIDTH  selected pixel
o_xcoord  out  COORD_WIDTH  destination x
o_ycoord  out  COORD_WIDTH  destination y
o_sof  out  1  first output of frame
o_eol  out  1  last output of a destination row
o_frame_done  out  1  one-cycle pulse after last source pixel consumed
o_err  out  1  sticky: sof seen mid-frame; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state IDLE; counters, accumulators, FIFO count 0; o_valid, o_sof, o_eol, o_frame_done, o_err = 0; o_pixel/coords = 0; o_ready = 1 after release.
- Input transfer = i_valid & o_ready. Output transfer = o_valid & i_ready.
- o_ready = (FIFO count < 2), registered from current count. No combinational path i_ready -> o_ready.
- States:
  - IDLE: transfers without i_sof are consumed and dropped. A transfer with i_sof latches step and goes to ACTIVE.
  - ACTIVE: the sof pixel itself is processed as source (0,0).
- Step latch: step_r = max(i_step, 1<<FRAC_BITS). Upscaling is clamped to 1.0.
- Source counters src_x, src_y advance per input transfer in raster order. Accumulators nx, ny are fixed-point with integer part compared to src_x/src_y. Both are 0 at sof.
- Selection: pixel is selected iff src_y == int(ny) and src_x == int(nx).
- On selection: push {pixel, dst_x, dst_y, sof, eol} into FIFO, nx += step_r, dst_x++.
- eol = (int(nx + step_r) > SRC_WIDTH-1), evaluated at selection.
- At src_x == SRC_WIDTH-1: nx = 0, dst_x = 0, src_x = 0. If the row was selected, ny += step_r and dst_y++.
- At (SRC_WIDTH-1, SRC_HEIGHT-1): o_frame_done pulses next cycle and state returns to IDLE.
- Latency: a selected pixel appears on o_valid the cycle after its input transfer when the FIFO is empty.
- Output stays stable while o_valid & !i_ready. Order is preserved and nothing is lost.
- Simultaneous push and pop with count==2 cannot occur, because o_ready was 0. Push and pop with count==1 leaves count at 1.
- i_sof while ACTIVE and not at (0,0): set o_err, restart the frame at that pixel, and relatch step. Entries already in the FIFO still drain.
- Accumulator width is COORD_WIDTH + FRAC_BITS internally, so there is no overflow for SRC dimensions below 2^(COORD_WIDTH-FRAC_BITS).
- Reset mid-frame: FIFO is flushed, partial frame is discarded, state returns to IDLE.

Decomposition:
- Shared package: FRAC_BITS default, ONE_STEP = 1<<FRAC_BITS, state enum {IDLE, ACTIVE}, and output beat record {pixel, x, y, sof, eol}.
- One sub-module: scaler_skid_fifo, a 2-entry valid/ready buffer of the beat record. It is reusable by the memory front-end.

Test Plan:
- 10x10 frame, i_pixel = 10*y + x, step 0x0200, i_ready=1 -> 25 outputs. Coords (0..4, 0..4); pixel = 20*dy + 2*dx; o_eol at dx=4; o_sof only on the first output; o_frame_done once.
- Step 0x0100 -> 100 outputs identical to the input, coords equal to source coords. Step 0x0080 gives the same result (clamped).
- Step 0x0180 (1.5) -> source x/y selected {0,1,3,4,6,7,9}; 49 outputs; output (6,6) carries pixel 99.
- Step 0x0200, i_ready held 0 for 6 cycles mid-row -> o_ready falls after 2 buffered beats. Output is held stable, and resumes with no loss or duplicate (25 outputs total, in order).
- i_sof reasserted at source (5,3) -> o_err=1 and stays set. Counters restart, and the following full frame produces the correct 25 outputs.
- reset_os pulled low at source (4,4) -> all outputs 0 during reset. Non-sof pixels after release are dropped; the next sof frame is correct.
